cpu_run_sequencer: RTL and testbench

Synthesizable run controller that replaces the hand-written clock/reset stimulus loop around `PipelinedCpu`. It holds the CPU in reset for a programmable number of cycles, then enables it for at most a bounded number of cycles. While the CPU runs, it watches the CPU's `OUT` bus and detects halt as the value staying stable. It then reports done, pass/fail against an expected result, or a timeout. It sits between the top level (or bench) and `PipelinedCpu`, driving the CPU's reset and clock-enable.

---
 rtl/cpu_run_pkg.sv | 22 ++
 rtl/cpu_run_sequencer_stable_detector.sv | 41 ++++
 rtl/cpu_run_sequencer.sv | 129 ++++++++++++
 tb/tb_cpu_run_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared types and defaults for the CPU run sequencer.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReset = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } run_state_e;

  localparam int unsigned DefDataW        = 32;
  localparam int unsigned DefRstCycles    = 2;
  localparam int unsigned DefMaxCycles    = 500;
  localparam int unsigned DefStableCycles = 4;
  localparam logic [31:0] DefExpectOut    = 32'd55;

  // Width of a counter that must reach max_cycles inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_run_sequencer_stable_detector.sv
// Tracks how many consecutive samples of d have been identical; flags halt.
module stable_detector #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic              stable
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  logic [DATA_W-1:0] prev_q;
  logic [SW-1:0]     stab_q, stab_d;

  // stab_q == 0 marks "no sample yet", so the first sample always restarts the run.
  always_comb begin
    stab_d = stab_q;
    if (stab_q == '0 || d != prev_q) begin
      stab_d = SW'(1);
    end else if (stab_q != SW'(STABLE_CYCLES)) begin
      stab_d = stab_q + SW'(1);
    end
  end

  assign stable = en && (stab_d == SW'(STABLE_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_q <= '0;
      stab_q <= '0;
    end else if (en) begin
      prev_q <= d;
      stab_q <= stab_d;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Run controller: holds the CPU in reset, runs it within a cycle budget and
// reports halt (stable output) with pass/fail, or timeout.
module cpu_run_sequencer
  import cpu_run_pkg::*;
#(
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned MAX_CYCLES    = DefMaxCycles,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter logic [DATA_W-1:0] EXPECT_OUT = DATA_W'(DefExpectOut),
  localparam int unsigned CNT_W = cnt_w(MAX_CYCLES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [DATA_W-1:0] CPU_OUT,
  output logic              CPU_RST,
  output logic              CPU_EN,
  output logic [CNT_W-1:0]  CYCLE_CNT,
  output logic              DONE,
  output logic              PASS,
  output logic              TIMEOUT,
  output logic [DATA_W-1:0] LAST_OUT
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  run_state_e        state_q, state_d;
  logic [RW-1:0]     rcnt_q;
  logic [CNT_W-1:0]  cyc_q;
  logic              pass_q, timeout_q;
  logic [DATA_W-1:0] last_q;
  logic              stable;
  logic              budget_hit;

  stable_detector #(
    .DATA_W        (DATA_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clk    (CLK),
    .rst    (RST),
    .clr    (state_q != StRun),
    .en     (state_q == StRun),
    .d      (CPU_OUT),
    .stable (stable)
  );

  // This RUN cycle's increment brings the count to the budget.
  assign budget_hit = (cyc_q == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (START) state_d = StReset;
      StReset: begin
        if (ABORT)             state_d = StIdle;
        else if (rcnt_q == '0) state_d = StRun;
      end
      StRun: begin
        if (ABORT)                     state_d = StIdle;
        else if (stable || budget_hit) state_d = StDone;
      end
      StDone:  if (START) state_d = StReset;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    CPU_RST = (state_q == StIdle) || (state_q == StReset);
    CPU_EN  = (state_q == StRun);
    DONE    = (state_q == StDone);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rcnt_q    <= '0;
      cyc_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (START) begin
            rcnt_q    <= RW'(RST_CYCLES - 1);
            cyc_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= '0;
          end
        end
        StReset: begin
          if (rcnt_q != '0) rcnt_q <= rcnt_q - RW'(1);
        end
        StRun: begin
          if (!ABORT) begin
            if (cyc_q != CNT_W'(MAX_CYCLES)) cyc_q <= cyc_q + CNT_W'(1);
            // Halt takes precedence over timeout on the same cycle.
            if (stable) begin
              last_q    <= CPU_OUT;
              pass_q    <= (CPU_OUT == EXPECT_OUT);
              timeout_q <= 1'b0;
            end else if (budget_hit) begin
              last_q    <= CPU_OUT;
              pass_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign CYCLE_CNT = cyc_q;
  assign PASS      = pass_q;
  assign TIMEOUT   = timeout_q;
  assign LAST_OUT  = last_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Scoreboard bench: a CPU stand-in plays a per-run-cycle output sequence while a
// reference model predicts each run's verdict and a monitor checks it at DONE.
module tb_cpu_run_sequencer;

  localparam int unsigned DW  = 32;
  localparam int unsigned RC  = 2;
  localparam int unsigned MC  = 500;
  localparam int unsigned SC  = 4;
  localparam logic [31:0] EXP = 32'd55;
  localparam int unsigned CW  = $clog2(MC + 1);

  logic          CLK = 1'b0;
  logic          RST, START, ABORT;
  logic [DW-1:0] CPU_OUT;
  logic          CPU_RST, CPU_EN, DONE, PASS, TIMEOUT;
  logic [CW-1:0] CYCLE_CNT;
  logic [DW-1:0] LAST_OUT;

  cpu_run_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .ABORT     (ABORT),
    .CPU_OUT   (CPU_OUT),
    .CPU_RST   (CPU_RST),
    .CPU_EN    (CPU_EN),
    .CYCLE_CNT (CYCLE_CNT),
    .DONE      (DONE),
    .PASS      (PASS),
    .TIMEOUT   (TIMEOUT),
    .LAST_OUT  (LAST_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          pass;
    bit          tmo;
    logic [31:0] last;
    int unsigned cnt;
  } res_t;

  res_t        exp_q[$];
  int unsigned seq[MC];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Verdict from the rules: the first index closing a run of SC equal samples
  // halts; otherwise the budget expires on the last sample.
  function automatic res_t model();
    res_t r;
    int   run = 0;
    r.pass = 1'b0; r.tmo = 1'b1; r.last = seq[MC-1]; r.cnt = MC;
    for (int i = 0; i < MC; i++) begin
      run = (i > 0 && seq[i] == seq[i-1]) ? run + 1 : 1;
      if (run >= SC) begin
        r.pass = (seq[i] == EXP); r.tmo = 1'b0; r.last = seq[i]; r.cnt = i + 1;
        return r;
      end
    end
    return r;
  endfunction

  // Monitor: every rising DONE consumes one prediction.
  always @(negedge CLK) begin : monitor
    res_t e;
    if (DONE && !done_seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("pass",      64'(PASS),      64'(e.pass));
        chk("timeout",   64'(TIMEOUT),   64'(e.tmo));
        chk("last_out",  64'(LAST_OUT),  64'(e.last));
        chk("cycle_cnt", 64'(CYCLE_CNT), 64'(e.cnt));
        chk("done_en",   64'(CPU_EN),    64'(0));
        chk("done_rst",  64'(CPU_RST),   64'(0));
      end
    end
    done_seen = DONE;
  end

  task automatic fill_rise(input int unsigned hold);
    for (int i = 0; i < MC; i++) seq[i] = (i < 10) ? i * (i + 1) / 2 : hold;
  endtask

  task automatic fill_toggle();
    for (int i = 0; i < MC; i++) seq[i] = i % 2;
  endtask

  // Constant from RUN cycle 497 (index 496) onward.
  task automatic fill_late(input int unsigned v);
    for (int i = 0; i < MC; i++) seq[i] = (i < 496) ? i % 2 : v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < MC; i++) seq[i] = 54 + $urandom_range(0, 2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_rst"},   64'(CPU_RST),   64'(1));
    chk({tag, "_cpu_en"},    64'(CPU_EN),    64'(0));
    chk({tag, "_done"},      64'(DONE),      64'(0));
    chk({tag, "_pass"},      64'(PASS),      64'(0));
    chk({tag, "_timeout"},   64'(TIMEOUT),   64'(0));
    chk({tag, "_cycle_cnt"}, 64'(CYCLE_CNT), 64'(0));
    chk({tag, "_last_out"},  64'(LAST_OUT),  64'(0));
  endtask

  // One run. abort_at/rst_at (RUN cycle numbers, 0 = never) cut the run short.
  task automatic do_run(input int abort_at, input int rst_at, input bit chk_clear);
    int  k = 0;
    int  rst_cnt = 0;
    bit  cut_abort = 1'b0;
    bit  cut_rst = 1'b0;
    bit  finished = 1'b0;
    if (abort_at == 0 && rst_at == 0) exp_q.push_back(model());
    @(negedge CLK);
    START = 1'b1;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
      if (cut_abort) begin
        chk("abort_done",    64'(DONE),    64'(0));
        chk("abort_cpu_rst", 64'(CPU_RST), 64'(1));
        chk("abort_cpu_en",  64'(CPU_EN),  64'(0));
        ABORT = 1'b0;
        return;
      end
      if (cut_rst) begin
        RST = 1'b0;
        check_reset_vals("midrun_rst");
        return;
      end
      if (cyc == 0 && chk_clear) begin
        chk("restart_done",      64'(DONE),      64'(0));
        chk("restart_pass",      64'(PASS),      64'(0));
        chk("restart_timeout",   64'(TIMEOUT),   64'(0));
        chk("restart_cycle_cnt", 64'(CYCLE_CNT), 64'(0));
      end
      if (DONE) begin
        finished = 1'b1;
        break;
      end
      if (CPU_RST) rst_cnt++;
      if (CPU_EN) begin
        CPU_OUT = (k < MC) ? seq[k] : 32'hDEAD_BEEF;
        k++;
        if (k == abort_at) begin
          ABORT = 1'b1;
          cut_abort = 1'b1;
        end
        if (k == rst_at) begin
          RST = 1'b1;
          cut_rst = 1'b1;
        end
      end
    end
    if (!finished) begin
      chk("run_bound_expired", 64'(1), 64'(0));
      return;
    end
    chk("cpu_rst_cycles", 64'(rst_cnt),   64'(RC));
    chk("cnt_vs_en",      64'(CYCLE_CNT), 64'(k));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; CPU_OUT = $urandom;
    repeat (2) begin
      @(negedge CLK);
      CPU_OUT = $urandom;
    end
    check_reset_vals("reset");
    RST = 1'b0;

    fill_rise(55);  do_run(0, 0, 1'b0);
    do_run(0, 0, 1'b1);           // restart from DONE, identical run
    fill_rise(54);  do_run(0, 0, 1'b1);
    fill_toggle();  do_run(0, 0, 1'b1);
    fill_late(55);  do_run(0, 0, 1'b0);
    fill_late(77);  do_run(0, 0, 1'b0);
    fill_toggle();  do_run(20, 0, 1'b0);
    fill_toggle();  do_run(0, 30, 1'b0);
    repeat (6) begin
      fill_random();
      do_run(0, 0, 1'b0);
    end

    repeat (3) @(negedge CLK);
    chk("pending_expectations", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
